fetch_stage: RTL and testbench

Instruction-fetch stage of the 6-stage IITB-RISC pipeline and the producing end of the IF/ID pipeline register consumed by the decode stage. It owns the program counter, reads one 16-bit instruction per cycle from instruction memory, and registers the instruction, its PC and PC+1 into IF/ID. It also applies hazard-unit stalls and branch/jump redirects, inserting NOP bubbles as required. A 16-bit fetched-instruction counter supports bring-up debug.

---
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 6-stage IITB-RISC pipeline.
// Owns the PC, reads one instruction per cycle from instruction memory and
// loads the IF/ID pipeline register. Redirects squash the instruction being
// fetched by loading a bubble; stalls freeze the PC and IF/ID together.
// The one-bit BOOT/RUN state is exposed on dbg_state_o for debug.
//
// Control semantics: there is no valid/ready handshake. Each rising edge
// applies exactly one action in priority order:
//   rst > redirect_en > stall > normal advance.
// if_id_valid=1 marks a real instruction and if_id_valid=0 marks a bubble.
// A bubble carries NOP_INSTR, which decodes with all enables low.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'hF000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic [15:0] if_id_pc_plus1,
  output logic        if_id_valid,
  output logic [15:0] fetch_count,
  output logic        dbg_state_o
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ifpc_q, ifpc_d;
  logic [15:0] ifpc1_q, ifpc1_d;
  logic        valid_q, valid_d;
  logic [15:0] cnt_q, cnt_d;

  // Next-state logic: hold everything by default, then apply the edge action.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    ifpc1_d = ifpc1_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      BOOT: begin
        // No fetch is committed in BOOT. A redirect can still move the PC.
        state_d = RUN;
        if (redirect_en) pc_d = redirect_pc;
      end
      RUN: begin
        if (redirect_en) begin
          // Squash the instruction at imem_data. The bubble keeps the old PC fields.
          pc_d    = redirect_pc;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d = imem_data;
          ifpc_d  = pc_q;
          ifpc1_d = pc_q + 16'd1;
          valid_d = 1'b1;
          pc_d    = pc_q + 16'd1;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ifpc_q  <= 16'h0000;
      ifpc1_q <= 16'h0000;
      valid_q <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      ifpc1_q <= ifpc1_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = ifpc_q;
  assign if_id_pc_plus1 = ifpc1_q;
  assign if_id_valid    = valid_q;
  assign fetch_count    = cnt_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random stimulus for fetch_stage. The reference
// model tracks the architectural PC, the IF/ID contents and the fetch count.
// It updates them on every edge from the edge-action rules.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'hF000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] imem_addr, imem_data;
  logic [15:0] if_id_instr, if_id_pc, if_id_pc_plus1, fetch_count;
  logic        if_id_valid, dbg_state_o;

  logic [15:0] imem [0:65535];
  assign imem_data = imem[imem_addr];

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_pc_plus1(if_id_pc_plus1), .if_id_valid(if_id_valid),
    .fetch_count(fetch_count), .dbg_state_o(dbg_state_o)
  );

  // reference model
  logic [15:0] m_pc, m_instr, m_ifpc, m_ifpc1, m_cnt;
  logic        m_valid, m_boot;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic model_edge();
    if (rst) begin
      m_pc = 16'h0000; m_instr = NOP; m_ifpc = 16'h0000; m_ifpc1 = 16'h0000;
      m_valid = 1'b0; m_cnt = 16'h0000; m_boot = 1'b1;
    end else if (m_boot) begin
      m_boot = 1'b0;
      if (redirect_en) m_pc = redirect_pc;
    end else if (redirect_en) begin
      m_pc = redirect_pc; m_instr = NOP; m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = imem[m_pc]; m_ifpc = m_pc; m_ifpc1 = m_pc + 16'd1;
      m_valid = 1'b1; m_pc = m_pc + 16'd1; m_cnt = m_cnt + 16'd1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_addr", imem_addr, m_pc);
    chk("instr", if_id_instr, m_instr);
    chk("if_pc", if_id_pc, m_ifpc);
    chk("if_pc1", if_id_pc_plus1, m_ifpc1);
    chk("valid", {15'd0, if_id_valid}, {15'd0, m_valid});
    chk("count", fetch_count, m_cnt);
    chk("run_state", {15'd0, dbg_state_o}, {15'd0, ~m_boot});
  endtask

  // driver: one edge, model update, check #1 later
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic r, input logic s, input logic re, input logic [15:0] rp);
    rst = r; stall = s; redirect_en = re; redirect_pc = rp;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) imem[i] = 16'($urandom);
    imem[0] = 16'h1111; imem[1] = 16'h2222; imem[2] = 16'h3333; imem[3] = 16'h4444;

    // reset / boot
    drive(1, 0, 0, 0);
    cycle(); cycle();
    chk("rst_instr", if_id_instr, 16'hF000);
    chk("rst_valid", {15'd0, if_id_valid}, 16'd0);
    drive(0, 0, 0, 0);
    cycle();
    chk("boot_valid", {15'd0, if_id_valid}, 16'd0);
    chk("boot_addr", imem_addr, 16'h0000);
    cycle();
    chk("f0_instr", if_id_instr, 16'h1111); chk("f0_pc", if_id_pc, 16'h0000);
    cycle();
    chk("f1_instr", if_id_instr, 16'h2222); chk("f1_pc", if_id_pc, 16'h0001);

    // stall 3 cycles at if_id_pc=1
    drive(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_pc", if_id_pc, 16'h0001); chk("stall_instr", if_id_instr, 16'h2222);
      chk("stall_cnt", fetch_count, 16'd2);
    end
    drive(0, 0, 0, 0);
    cycle();
    chk("post_stall_instr", if_id_instr, 16'h3333); chk("post_stall_pc", if_id_pc, 16'h0002);
    chk("cnt3", fetch_count, 16'd3);

    // redirect
    drive(0, 0, 1, 16'h0040);
    cycle();
    chk("redir_valid", {15'd0, if_id_valid}, 16'd0); chk("redir_nop", if_id_instr, 16'hF000);
    chk("redir_addr", imem_addr, 16'h0040);
    drive(0, 0, 0, 0);
    cycle();
    chk("tgt_pc", if_id_pc, 16'h0040); chk("tgt_pc1", if_id_pc_plus1, 16'h0041);
    chk("tgt_valid", {15'd0, if_id_valid}, 16'd1);

    // redirect + stall on the same edge
    drive(0, 1, 1, 16'h0100);
    cycle();
    chk("rs_valid", {15'd0, if_id_valid}, 16'd0); chk("rs_addr", imem_addr, 16'h0100);

    // wrap of pc
    drive(0, 0, 1, 16'hFFFF);
    cycle();
    drive(0, 0, 0, 0);
    cycle();
    chk("wrap_pc", if_id_pc, 16'hFFFF); chk("wrap_pc1", if_id_pc_plus1, 16'h0000);
    cycle();
    chk("wrap_next", if_id_pc, 16'h0000);

    // fetch_count wrap
    while (m_cnt != 16'hFFFF) cycle();
    chk("cnt_ffff", fetch_count, 16'hFFFF);
    cycle();
    chk("cnt_wrap", fetch_count, 16'h0000);

    // mid-run reset with stall and redirect
    drive(1, 1, 1, 16'h0BAD);
    cycle();
    chk("mrst_valid", {15'd0, if_id_valid}, 16'd0); chk("mrst_cnt", fetch_count, 16'd0);
    chk("mrst_addr", imem_addr, 16'h0000); chk("mrst_instr", if_id_instr, 16'hF000);
    drive(0, 1, 0, 0);
    cycle();
    chk("reboot_valid", {15'd0, if_id_valid}, 16'd0);
    drive(0, 0, 0, 0);
    cycle();
    chk("reboot_f0", if_id_instr, 16'h1111);

    // random phase
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), 16'($urandom));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
